// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz stimulus/checker harnesses.
// Holds the run-state encoding and the 16-bit LFSR definition.
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/quiz_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and single-step advance.
// Load and step together yield the successor of the seed in one cycle.
module quiz_lfsr16
  import quiz_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_load,
  input  logic        i_step,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= i_step ? lfsr_next(SEED) : SEED;
    end else if (i_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/quiz_stim_checker.sv
// Issues one LFSR vector per cycle to a reference/candidate pair and compares
// their results LATENCY cycles later, keeping pass/fail counts and first mismatch.
module quiz_stim_checker
  import quiz_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          NUM_VECTORS = 256,
  parameter int          LATENCY     = 0,
  parameter logic [15:0] SEED        = DEFAULT_SEED,
  parameter int          CNT_W       = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] z_true,
  input  logic [DATA_W-1:0] z_test,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_x,
  output logic [DATA_W-1:0] first_err_y
);

  localparam logic [CNT_W-1:0] NUM_V    = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t              r_state;
  logic                r_start_d;
  logic [DATA_W-1:0]   r_x, r_y;
  logic                r_vld;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic                r_busy, r_done, r_pass;
  logic [CNT_W-1:0]    r_vec_cnt, r_err_cnt;
  logic                r_fe_valid;
  logic [CNT_W-1:0]    r_fe_idx;
  logic [DATA_W-1:0]   r_fe_x, r_fe_y;

  logic                w_start_rise, w_start_go, w_issue;
  logic [15:0]         w_lfsr_q, w_vec;
  logic [DATA_W-1:0]   w_vec_x, w_vec_y;
  logic                w_cmp_vld;
  logic [CNT_W-1:0]    w_cmp_idx;
  logic [DATA_W-1:0]   w_cmp_x, w_cmp_y;
  logic                w_mismatch, w_last_cmp;
  logic [CNT_W-1:0]    w_err_next;

  // Edge-detect start so a held request launches only one run.
  assign w_start_rise = start & ~r_start_d;
  assign w_start_go   = w_start_rise && (r_state == IDLE || r_state == DONE);
  assign w_issue      = (r_state == RUN) && (r_issue_cnt != NUM_V);

  quiz_lfsr16 #(.SEED(SEED)) u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_load  (w_start_go),
    .i_step  (w_start_go | w_issue),
    .o_value (w_lfsr_q)
  );

  assign w_vec   = w_start_go ? SEED : w_lfsr_q;
  assign w_vec_x = DATA_W'(w_vec[15:8]);
  assign w_vec_y = DATA_W'(w_vec[7:0]);

  generate
    if (LATENCY == 0) begin : g_nodelay
      assign w_cmp_vld = r_vld;
      assign w_cmp_idx = r_idx;
      assign w_cmp_x   = r_x;
      assign w_cmp_y   = r_y;
    end else begin : g_delay
      logic              r_dl_vld [LATENCY];
      logic [CNT_W-1:0]  r_dl_idx [LATENCY];
      logic [DATA_W-1:0] r_dl_x   [LATENCY];
      logic [DATA_W-1:0] r_dl_y   [LATENCY];

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          for (int i = 0; i < LATENCY; i++) r_dl_vld[i] <= 1'b0;
        end else begin
          r_dl_vld[0] <= r_vld;
          for (int i = 1; i < LATENCY; i++) r_dl_vld[i] <= r_dl_vld[i-1];
        end
      end

      always_ff @(posedge sys_clk) begin
        r_dl_idx[0] <= r_idx;
        r_dl_x[0]   <= r_x;
        r_dl_y[0]   <= r_y;
      end

      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        always_ff @(posedge sys_clk) begin
          r_dl_idx[gi] <= r_dl_idx[gi-1];
          r_dl_x[gi]   <= r_dl_x[gi-1];
          r_dl_y[gi]   <= r_dl_y[gi-1];
        end
      end

      assign w_cmp_vld = r_dl_vld[LATENCY-1];
      assign w_cmp_idx = r_dl_idx[LATENCY-1];
      assign w_cmp_x   = r_dl_x[LATENCY-1];
      assign w_cmp_y   = r_dl_y[LATENCY-1];
    end
  endgenerate

  assign w_mismatch = (z_true != z_test);
  assign w_last_cmp = w_cmp_vld && (w_cmp_idx == LAST_IDX);
  assign w_err_next = (w_cmp_vld && w_mismatch && (r_err_cnt != '1))
                      ? r_err_cnt + CNT_W'(1) : r_err_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_start_d   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_vld       <= 1'b0;
      r_idx       <= '0;
      r_issue_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_idx    <= '0;
      r_fe_x      <= '0;
      r_fe_y      <= '0;
    end else begin
      r_start_d <= start;
      r_vld     <= 1'b0;

      if (w_cmp_vld) begin
        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        r_err_cnt <= w_err_next;
        if (w_mismatch && !r_fe_valid) begin
          r_fe_valid <= 1'b1;
          r_fe_idx   <= w_cmp_idx;
          r_fe_x     <= w_cmp_x;
          r_fe_y     <= w_cmp_y;
        end
      end

      if (w_start_go || w_issue) begin
        r_x         <= w_vec_x;
        r_y         <= w_vec_y;
        r_vld       <= 1'b1;
        r_idx       <= w_start_go ? '0 : r_issue_cnt;
        r_issue_cnt <= w_start_go ? CNT_W'(1) : r_issue_cnt + CNT_W'(1);
      end

      case (r_state)
        IDLE, DONE: begin
          if (w_start_go) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_fe_valid <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_x     <= '0;
            r_fe_y     <= '0;
          end
        end
        RUN, DRAIN: begin
          if (w_last_cmp) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else if (r_state == RUN && !w_issue && LATENCY != 0) begin
            r_state <= DRAIN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x               = r_x;
  assign y               = r_y;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign vec_cnt         = r_vec_cnt;
  assign err_cnt         = r_err_cnt;
  assign first_err_valid = r_fe_valid;
  assign first_err_idx   = r_fe_idx;
  assign first_err_x     = r_fe_x;
  assign first_err_y     = r_fe_y;

endmodule

// File: doc/quiz_stim_checker.md
Name: quiz_stim_checker

Overview:
- Synthesizable on-FPGA stimulus generator and result checker for quiz reference/answer pairs.
- Drives x/y operand buses into a unit that exposes z_true (reference answer) and z_test (student answer).
- Issues one pseudo-random vector per cycle, compares the two results after a fixed DUT latency, and reports pass/fail counts plus the first mismatch for readout over LEDs or UART.

Parameters:
- DATA_W, 8, width of x, y, z_true, z_test.
- NUM_VECTORS, 256, number of vectors issued per run (1..65535).
- LATENCY, 0, DUT pipeline depth in cycles between operand presentation and result sampling (0..15).
- SEED, 16'hACE1, LFSR load value at run start; must be nonzero.
- CNT_W, 16, width of vector and error counters.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- sys_rst  input  1  reset; synchronous, active-high.
- start  input  1  single-cycle run request; honoured only in IDLE or DONE.
- x  output  DATA_W  operand A to DUT; registered.
- y  output  DATA_W  operand B to DUT; registered.
- z_true  input  DATA_W  reference result from DUT pair.
- z_test  input  DATA_W  candidate result from DUT pair.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; holds until next start or reset.
- pass  output  1  valid when done=1: high iff err_cnt==0.
- vec_cnt  output  CNT_W  number of vectors compared so far.
- err_cnt  output  CNT_W  number of mismatches; saturates at all-ones.
- first_err_valid  output  1  a mismatch has been captured this run.
- first_err_idx  output  CNT_W  index of the first mismatching vector.
- first_err_x  output  DATA_W  x of the first mismatch.
- first_err_y  output  DATA_W  y of the first mismatch.

Behaviour:
- Reset: state=IDLE; LFSR=SEED; all outputs 0 (x, y, busy, done, pass, counters, first_err_*). Reset in any state, including mid-run, aborts to IDLE with these values.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; feedback shifts into bit 0.
  - Vector operands: x = lfsr[15:8], y = lfsr[7:0], each zero-extended or truncated to DATA_W.
  - Vector 0 = SEED (x=8'hAC, y=8'hE1 by default). The LFSR advances once per issued vector.
- States:
  - IDLE: start -> RUN. Clear counters and first_err_*; load LFSR=SEED.
  - RUN: on each cycle, register the current vector onto x/y and advance the LFSR. After NUM_VECTORS issues -> DRAIN, or -> DONE when LATENCY=0 and the last compare has occurred.
  - DRAIN: no new issues; x/y hold the last vector. Remain until the delay pipe is empty -> DONE.
  - DONE: start -> RUN, with the same clearing as from IDLE.
- Start handling: start is ignored while busy. Start pulses wider than 1 cycle are treated as one pulse.
- Issue/compare pipeline:
  - A valid bit and the vector index travel with each vector through a delay line of LATENCY stages.
  - A vector is presented on x/y in cycle k. z_true and z_test are sampled in cycle k+LATENCY, when the delayed valid is high.
  - At each compare: vec_cnt+1. If z_true!=z_test, err_cnt+1 (saturating at all-ones).
  - On the first mismatch of a run, capture idx, x, y (from the delay line) and set first_err_valid. Later mismatches do not overwrite the capture.
- Timing: start sampled in cycle T -> first vector on x/y in cycle T+1 -> done=1 in cycle T+1+NUM_VECTORS+LATENCY. busy is high from T+1 through the cycle before done.
- Comparison is a bitwise equality over all DATA_W bits. X/Z on the inputs is not handled specially.
- pass = done & (err_cnt==0). Outputs remain stable in DONE.

Decomposition:
- Shared package quiz_pkg holds:
  - state enum: IDLE, RUN, DRAIN, DONE;
  - LFSR tap constant;
  - default SEED.
- One sub-module, quiz_lfsr16: parameterised seed, with load, step, and 16-bit value output. It is reused by future quiz harnesses.
- Delay line, FSM, and counters stay in the top module.

Test Plan:
- Matched DUT (z_true=z_test=|x-y|), LATENCY=0, NUM_VECTORS=256; pulse start -> first x=8'hAC, y=8'hE1; done at T+257; vec_cnt=256, err_cnt=0, pass=1, first_err_valid=0.
- Faulty DUT (z_test = z_true^8'h01 only for vector index 5) -> err_cnt=1, pass=0, first_err_idx=5, first_err_x/y equal the 6th LFSR vector.
- Always-wrong DUT, NUM_VECTORS=20 -> err_cnt=20, first_err_idx=0, first_err_x=8'hAC, first_err_y=8'hE1.
- LATENCY=3 with a 3-stage registered matched DUT -> err_cnt=0; done at T+1+NUM_VECTORS+3; a LATENCY-mismatched bench (DUT depth 2) -> err_cnt>0.
- Assert sys_rst for 1 cycle at vector 100 of a run -> next cycle IDLE, all outputs 0; a following start reproduces vector 0=8'hAC/8'hE1.
- Start pulsed during RUN -> ignored, run length unchanged. Start pulsed in DONE -> counters clear, and the new run repeats an identical sequence and results.
